// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save accumulator sequencer.
package csa_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} csa_seq_state_t;

  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

  // Widened so that MAX_OPS full-scale operands can never overflow the total.
  function automatic int acc_width(input int w, input int max_ops);
    return w + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor: a+b+c == s + cy, with cy already shifted into weight position.
module csa_row #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] s,
  output logic [ACC_W-1:0] cy
);

  logic [ACC_W-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  // MSB of maj is dropped; it is always 0 because the job sum fits in ACC_W.
  assign cy  = maj << 1;

endmodule

// File: rtl/csa_accum_seq.sv
// Sums a job of unsigned operands in carry-save form, then resolves with one carry-propagate add.
// Handshakes: a transfer occurs on a rising edge where valid && ready; producers hold data while valid.
module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int W       = 5,
  parameter int MAX_OPS = 8,
  localparam int CNT_W  = cnt_width(MAX_OPS),
  localparam int ACC_W  = acc_width(W, MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  output logic             busy,
  output logic             err,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] MAX_OPS_C = CNT_W'(MAX_OPS);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  csa_seq_state_t   state;
  logic [ACC_W-1:0] s_reg;
  logic [ACC_W-1:0] c_reg;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] row_s;
  logic [ACC_W-1:0] row_c;

  assign x_ext = ACC_W'(op_data);

  csa_row #(.ACC_W(ACC_W)) u_row (
    .a  (s_reg),
    .b  (c_reg),
    .c  (x_ext),
    .s  (row_s),
    .cy (row_c)
  );

  // Status outputs are pure decodes of the state register.
  assign busy      = (state != IDLE);
  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_reg     <= '0;
      c_reg     <= '0;
      res_data  <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_ops == '0) begin
              res_data <= '0;
              state    <= DONE;
            end else if (num_ops > MAX_OPS_C) begin
              err <= 1'b1;
            end else begin
              s_reg     <= '0;
              c_reg     <= '0;
              remaining <= num_ops;
              state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (op_valid) begin
            s_reg     <= row_s;
            c_reg     <= row_c;
            remaining <= remaining - ONE_C;
            if (remaining == ONE_C) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          res_data <= s_reg + c_reg;
          state    <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed and random jobs against a plain-arithmetic sum model with an expected-result queue.
module tb_csa_accum_seq;

  localparam int W       = 5;
  localparam int MAX_OPS = 8;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             busy;
  logic             err;
  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  csa_accum_seq #(.W(W), .MAX_OPS(MAX_OPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .busy      (busy),
    .err       (err),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_op_ready"}, 32'(op_ready), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic do_start(input int n);
    start   = 1'b1;
    num_ops = CNT_W'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] x);
    int  waited;
    logic accepted;
    op_valid = 1'b1;
    op_data  = x;
    waited   = 0;
    accepted = 1'b0;
    while (!accepted && waited < 50) begin
      accepted = op_ready;
      @(negedge clk);
      waited++;
    end
    op_valid = 1'b0;
    if (!accepted) check("op_timeout", 0, 1);
  endtask

  task automatic get_result(input string tag, input int hold);
    int   waited;
    logic [ACC_W-1:0] exp_v;
    waited = 0;
    while (!res_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_res_data"}, 32'(res_data), 32'(exp_v));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(res_valid), 1);
      check({tag, "_hold_data"}, 32'(res_data), 32'(exp_v));
      check({tag, "_hold_op_ready"}, 32'(op_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_after_accept_valid"}, 32'(res_valid), 0);
    check({tag, "_after_accept_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int sum;
    int n;
    logic [W-1:0] x;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_ops   = '0;
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // three 15s, latency check: RESOLVE cycle first, DONE next
    do_start(3);
    exp_q.push_back(ACC_W'(45));
    send_op(5'd15);
    send_op(5'd15);
    send_op(5'd15);
    check("lat_resolve_valid", 32'(res_valid), 0);
    check("lat_resolve_busy", 32'(busy), 1);
    @(negedge clk);
    check("lat_done_valid", 32'(res_valid), 1);
    get_result("t1", 0);

    // eight 31s with a gap between every operand
    do_start(8);
    exp_q.push_back(ACC_W'(248));
    for (int i = 0; i < 8; i++) begin
      send_op(5'd31);
      if (i < 7) begin
        check("t2_gap_ready", 32'(op_ready), 1);
        @(negedge clk);
      end
    end
    get_result("t2", 0);

    // consumer stalls five cycles
    do_start(2);
    exp_q.push_back(ACC_W'(20));
    send_op(5'd10);
    send_op(5'd10);
    get_result("t3", 5);

    // zero-operand job goes straight to DONE
    do_start(0);
    check("t4_zero_op_ready", 32'(op_ready), 0);
    exp_q.push_back('0);
    get_result("t4_zero", 0);

    // oversize job is rejected with a single err pulse
    do_start(9);
    check("t4_err_pulse", 32'(err), 1);
    check("t4_err_busy", 32'(busy), 0);
    @(negedge clk);
    check("t4_err_clear", 32'(err), 0);
    check("t4_err_busy2", 32'(busy), 0);

    // reset mid-job discards the partial sum
    do_start(4);
    send_op(5'd4);
    send_op(5'd6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1);
    exp_q.push_back(ACC_W'(12));
    send_op(5'd12);
    get_result("t5", 0);

    // op_valid in IDLE is ignored
    op_valid = 1'b1;
    op_data  = 5'd7;
    repeat (3) @(negedge clk);
    check("t6_idle_busy", 32'(busy), 0);
    check("t6_idle_ready", 32'(op_ready), 0);
    op_valid = 1'b0;

    // start during ACCUM and DONE is ignored
    do_start(2);
    start   = 1'b1;
    num_ops = CNT_W'(5);
    @(negedge clk);
    start   = 1'b0;
    exp_q.push_back(ACC_W'(9));
    send_op(5'd3);
    send_op(5'd6);
    @(negedge clk);
    start   = 1'b1;
    num_ops = CNT_W'(3);
    @(negedge clk);
    check("t6_done_start_valid", 32'(res_valid), 1);
    // start coincident with the result handshake is dropped too
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check("t6_same_cycle_busy", 32'(busy), 0);
    check("t6_res_data", 32'(res_data), 32'(exp_q.pop_front()));

    // random jobs
    for (int j = 0; j < 25; j++) begin
      n   = $urandom_range(0, MAX_OPS);
      sum = 0;
      do_start(n);
      for (int i = 0; i < n; i++) begin
        x   = W'($urandom);
        sum = sum + int'(x);
        send_op(x);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      exp_q.push_back(ACC_W'(sum));
      get_result("rand", $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
